// File: rtl/sprite_animator_pkg.sv
// Shared definitions for the sprite animator.
//   rgb444_t           : 4/4/4 colour triple
//   SCREEN_W/SCREEN_H  : visible raster size
//   anim_state_e       : animation controller states
//   sprite_rom_texel() : sprite ROM contents, one 4-bit palette index per address
//   palette_lookup()   : combinational 16-entry palette
package sprite_animator_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } anim_state_e;

    // Procedural ROM image: a mix of column, row (addr/64) and frame (addr/4096)
    // so every frame differs, index 3 sits at address 0 and index 0 (transparent
    // with the default TRANSP_IDX) appears scattered through each frame.
    function automatic logic [3:0] sprite_rom_texel(input logic [31:0] addr);
        return 4'(addr + (addr >> 6) * 32'd5 + (addr >> 12) * 32'd7 + 32'd3);
    endfunction

    function automatic rgb444_t palette_lookup(input logic [3:0] idx);
        rgb444_t c;
        c.r = idx;
        c.g = ~idx;
        c.b = idx ^ 4'd5;
        return c;
    endfunction

endpackage

// File: rtl/sprite_animator_ctrl.sv
// Animation controller: frame-boundary detector, tick counter and
// IDLE/PLAY/DONE sequencing of the displayed animation frame.
//   clk, rst_n     : pixel clock, async active-low reset
//   draw_x, draw_y : current scan position
//   play, loop     : run animation / wrap after last frame
//   frame_start    : one-cycle frame boundary pulse (combinational)
//   cur_frame      : registered displayed frame
//   anim_done      : non-looping sequence has finished
module sprite_anim_ctrl
    import sprite_animator_pkg::*;
#(
    parameter int unsigned N_FRAMES        = 4,
    parameter int unsigned TICKS_PER_FRAME = 8,
    parameter int unsigned FRAME_W         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               play,
    input  logic               loop,
    output logic               frame_start,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               anim_done
);

    localparam int unsigned TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 1);

    anim_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               origin_q, origin_d;
    logic               at_origin;

    // Boundary fires once on entering (0,0), not for every cycle parked there.
    assign at_origin   = (draw_x == '0) && (draw_y == '0);
    assign frame_start = at_origin && !origin_q;
    assign cur_frame   = frame_q;
    assign anim_done   = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            tick_q   <= '0;
            origin_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            tick_q   <= tick_d;
            origin_q <= origin_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        tick_d   = tick_q;
        origin_d = at_origin;
        case (state_q)
            ST_IDLE: begin
                frame_d = '0;
                tick_d  = '0;
                if (play) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (!play) begin
                    state_d = ST_IDLE;
                    frame_d = '0;
                    tick_d  = '0;
                end else if (frame_start) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (frame_q == FRAME_LAST) begin
                            if (loop) frame_d = '0;
                            else      state_d = ST_DONE;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!play) begin
                    state_d = ST_IDLE;
                    frame_d = '0;
                    tick_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/sprite_animator.sv
// Animated, scaled sprite composited over a background video stream.
//   vga_clk, reset_n         : pixel clock, async active-low reset
//   DrawX, DrawY, blank      : scan position and active-video flag
//   pos_x, pos_y             : sprite top-left, latched at each frame boundary
//   play, loop               : animation control
//   bg_red/green/blue        : background pixel aligned with DrawX/DrawY
//   red/green/blue           : composited pixel, 2 cycles after its inputs
//   sprite_hit               : output pixel is an opaque sprite texel
//   cur_frame, anim_done     : animation status
module sprite_animator
    import sprite_animator_pkg::*;
#(
    parameter int unsigned SPR_W           = 64,
    parameter int unsigned SPR_H           = 64,
    parameter int unsigned N_FRAMES        = 4,
    parameter int unsigned SCALE_SHIFT     = 1,
    parameter int unsigned TICKS_PER_FRAME = 8,
    parameter int unsigned TRANSP_IDX      = 0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       play,
    input  logic       loop,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       sprite_hit,
    output logic [((N_FRAMES > 1) ? $clog2(N_FRAMES) : 1)-1:0] cur_frame,
    output logic       anim_done
);

    localparam int unsigned FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam logic [10:0] SPAN_X  = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0] SPAN_Y  = 11'(SPR_H << SCALE_SHIFT);

    logic        frame_start;
    logic [9:0]  px_q, px_d, py_q, py_d;
    logic        pos_valid_q, pos_valid_d;
    logic        s1_valid_q, s1_valid_d;
    logic [3:0]  s1_idx_q, s1_idx_d;
    logic        s1_hit_q, s1_hit_d;
    logic        s1_blank_q, s1_blank_d;
    rgb444_t     s1_bg_q, s1_bg_d;
    rgb444_t     pix_q, pix_d;
    logic        hit_q, hit_d;

    logic [10:0] x11, y11, px11, py11, dx, dy;
    logic        in_sprite, opaque;
    logic [31:0] col, row, rom_addr;

    sprite_anim_ctrl #(
        .N_FRAMES       (N_FRAMES),
        .TICKS_PER_FRAME(TICKS_PER_FRAME),
        .FRAME_W        (FRAME_W)
    ) u_ctrl (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .draw_x     (DrawX),
        .draw_y     (DrawY),
        .play       (play),
        .loop       (loop),
        .frame_start(frame_start),
        .cur_frame  (cur_frame),
        .anim_done  (anim_done)
    );

    // Stage 1: position latch, hit test, ROM address and registered ROM read.
    always_comb begin
        px_d        = frame_start ? pos_x : px_q;
        py_d        = frame_start ? pos_y : py_q;
        pos_valid_d = pos_valid_q | frame_start;

        x11  = {1'b0, DrawX};
        y11  = {1'b0, DrawY};
        px11 = {1'b0, px_q};
        py11 = {1'b0, py_q};
        dx   = x11 - px11;
        dy   = y11 - py11;
        // 11-bit compares keep px+span from wrapping; screen limits clip the rest.
        in_sprite = pos_valid_q
                 && (x11 >= px11) && (x11 < px11 + SPAN_X)
                 && (y11 >= py11) && (y11 < py11 + SPAN_Y)
                 && (x11 < 11'(SCREEN_W)) && (y11 < 11'(SCREEN_H));
        col      = 32'(dx >> SCALE_SHIFT);
        row      = 32'(dy >> SCALE_SHIFT);
        rom_addr = 32'(cur_frame) * (SPR_W * SPR_H) + row * SPR_W + col;

        s1_valid_d = 1'b1;
        s1_idx_d   = sprite_rom_texel(rom_addr);
        s1_hit_d   = in_sprite;
        s1_blank_d = blank;
        s1_bg_d    = {bg_red, bg_green, bg_blue};
    end

    // Stage 2: transparency, palette and blanking into the output register.
    always_comb begin
        opaque = s1_hit_q && (s1_idx_q != 4'(TRANSP_IDX));
        pix_d  = '0;
        hit_d  = 1'b0;
        if (s1_valid_q && s1_blank_q) begin
            if (opaque) begin
                pix_d = palette_lookup(s1_idx_q);
                hit_d = 1'b1;
            end else begin
                pix_d = s1_bg_q;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            px_q        <= '0;
            py_q        <= '0;
            pos_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_hit_q    <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_bg_q     <= '0;
            pix_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            pos_valid_q <= pos_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_hit_q    <= s1_hit_d;
            s1_blank_q  <= s1_blank_d;
            s1_bg_q     <= s1_bg_d;
            pix_q       <= pix_d;
            hit_q       <= hit_d;
        end
    end

    assign red        = pix_q.r;
    assign green      = pix_q.g;
    assign blue       = pix_q.b;
    assign sprite_hit = hit_q;

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameter: SPR_W, 64, sprite width in source pixels.
REQ-002 Parameter: SPR_H, 64, sprite height in source pixels.
REQ-003 Parameter: N_FRAMES, 4, animation frames stored back-to-back in ROM.
REQ-004 Parameter: SCALE_SHIFT, 1, on-screen magnification 2^SCALE_SHIFT per axis.
REQ-005 Parameter: TICKS_PER_FRAME, 8, video frames per animation step.
REQ-006 Parameter: TRANSP_IDX, 0, palette index treated as transparent.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 vga_clk  in  1  pixel clock.
REQ-009 reset_n  in  1  async active-low reset.
REQ-010 DrawX, DrawY  in  10 each  current scan position.
REQ-011 blank  in  1  1 = active video.
REQ-012 pos_x, pos_y  in  10 each  sprite top-left on screen.
REQ-013 play  in  1  level; run animation while high.
REQ-014 loop  in  1  1 = wrap to frame 0 after last frame.
REQ-015 bg_red, bg_green, bg_blue  in  4 each  background pixel, DrawX/DrawY-aligned.
REQ-016 red, green, blue  out  4 each  composited pixel.
REQ-017 sprite_hit  out  1  opaque sprite pixel on current output.
REQ-018 cur_frame  out  $clog2(N_FRAMES)  displayed frame.
REQ-019 anim_done  out  1  non-loop sequence finished.

Function
REQ-020 Frame boundary: single cycle where DrawX==0 and DrawY==0 and the previous cycle did not match.
REQ-021 pos_x/pos_y captured into internal registers only on frame boundary; mid-frame changes SHALL not affect the current frame.
REQ-022 Hit: DrawX in [px, px+(SPR_W<<SCALE_SHIFT)) and DrawY in [py, py+(SPR_H<<SCALE_SHIFT)), compared in 11 bits; no wrap, off-screen portions clipped.
REQ-023 ROM address = cur_frame*SPR_W*SPR_H + ((DrawY-py)>>SCALE_SHIFT)*SPR_W + ((DrawX-px)>>SCALE_SHIFT); no divider.
REQ-024 Latency DrawX/DrawY/blank/bg -> RGB SHALL be exactly 2 cycles: stage 1 registered ROM read, stage 2 output register; hit, blank, bg pipelined alongside.
REQ-025 Output: blank=0 -> 0/0/0; else hit and index!=TRANSP_IDX -> palette colour, sprite_hit=1; else bg colour, sprite_hit=0.
REQ-026 FSM states IDLE, PLAY, DONE; transitions evaluated every cycle, frame/tick updates only on frame boundary.
REQ-027 IDLE: cur_frame=0, tick=0; play=1 -> PLAY.
REQ-028 PLAY: per boundary tick++; at tick==TICKS_PER_FRAME-1 tick->0 and frame advances.
REQ-029 PLAY at last frame advancing: loop=1 -> frame 0, stay PLAY; loop=0 -> DONE, hold last frame.
REQ-030 DONE: anim_done=1, frame held; play=0 -> IDLE.
REQ-031 play=0 in PLAY -> IDLE next cycle, frame and tick to 0, even mid-frame.
REQ-032 cur_frame changes only on boundary or via REQ-031; frame used for addressing is the registered cur_frame.

Reset
REQ-033 reset_n low: state IDLE, cur_frame 0, tick 0, anim_done 0, sprite_hit 0, RGB 0, pipeline valid bits 0, latched position 0.
REQ-034 Reset release mid-frame: no sprite drawn until first boundary latches position.

Structure
REQ-035 Shared package: rgb444 struct, screen constants 640/480, FSM state enum.
REQ-036 Sub-module sprite_anim_ctrl holds FSM, tick counter, boundary detect; ROM and combinational palette instantiated in sprite_animator.

Verification
REQ-037 Reset mid-frame, pos=(100,50), scan -> no hit before first boundary; after boundary first opaque pixel at DrawX=100, DrawY=50, RGB 2 cycles later.
REQ-038 SCALE_SHIFT=1, ROM row0 col0=idx 3 -> screen pixels (100..101,50..51) all palette[3]; (228,50) bg.
REQ-039 TRANSP_IDX texel -> bg colour passes through, sprite_hit=0; blank=0 -> RGB 0 regardless.
REQ-040 play=1, loop=0, TICKS=8, N=4 -> frame steps every 8 boundaries, DONE after 32, cur_frame holds 3, anim_done=1; play=0 -> frame 0.
REQ-041 loop=1 -> sequence 0,1,2,3,0; play dropped mid-frame -> IDLE, frame 0 next cycle.
REQ-042 pos_x=600 -> sprite clipped at DrawX=639, no pixels at DrawX 0..63 of next line.
